fpu_dp_divider: RTL

- Iterative IEEE-754 double-precision divider (a / b) for the FPU. It is the multi-cycle counterpart to the combinational adder.
- Accepts one operation per start pulse and computes one quotient bit per clock by restoring division.
- Rounds to nearest-even and reports overflow/underflow with the same flag semantics as the adder, plus divide-by-zero.
- Feeds the FPU result mux; the issuer waits on done.

---
 rtl/fpu_dp_divider_if.sv | 32 +++
 rtl/fpu_dp_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_dp_divider_if.sv
// Handshake and result bus between the FPU issuer and the iterative divider.
// The inexact signal is only present when FPU_DIV_INEXACT_EN is defined.
interface fpu_dp_divider_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
`ifdef FPU_DIV_INEXACT_EN
    logic        inexact;
`endif

    modport master (
`ifdef FPU_DIV_INEXACT_EN
        input  inexact,
`endif
        output start, a, b,
        input  busy, done, result, overflow, underflow, div_by_zero
    );

    modport slave (
`ifdef FPU_DIV_INEXACT_EN
        output inexact,
`endif
        input  start, a, b,
        output busy, done, result, overflow, underflow, div_by_zero
    );
endinterface

// File: rtl/fpu_dp_divider.sv
// Iterative IEEE-754 binary64 divider: restoring division, one quotient bit per clock,
// round-to-nearest-even, flush-to-zero. Define FPU_DIV_INEXACT_EN to add the inexact flag.
module fpu_dp_divider #(
    parameter int WIDTH = 64,
    parameter int QBITS = 55
) (
    input logic             clk,
    input logic             rst_n,
    fpu_dp_divider_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREP   = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam int         CW       = $clog2(QBITS);

    logic [2:0]         state;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               sign_r;
    logic signed [12:0] exp_r;
    logic [52:0]        mb_r;
    logic [53:0]        rem_r;
    logic [QBITS-1:0]   q_r;
    logic [CW-1:0]      cnt_r;
    logic               busy_r, done_r, ovf_r, unf_r, dbz_r;
    logic [WIDTH-1:0]   res_r;
`ifdef FPU_DIV_INEXACT_EN
    logic               inx_r;
`endif

    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a_r[62:52];
    assign eb     = b_r[62:52];
    assign fa     = a_r[51:0];
    assign fb     = b_r[51:0];
    assign sign   = a_r[63] ^ b_r[63];
    // Subnormal inputs count as zero, so only the exponent field decides zero-ness.
    assign a_zero = (ea == 11'd0);
    assign b_zero = (eb == 11'd0);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);

    logic        ge;
    logic [53:0] diff;

    assign ge   = (rem_r >= {1'b0, mb_r});
    assign diff = rem_r - {1'b0, mb_r};

    logic [QBITS-1:0]   qn;
    logic signed [12:0] en, ef;
    logic [52:0]        sig;
    logic [51:0]        mant;
    logic [53:0]        sum;
    logic               g, s, inc, ovf_n, unf_n;

    always_comb begin
        qn = q_r;
        en = exp_r;
        if (!q_r[QBITS-1]) begin
            qn = {q_r[QBITS-2:0], 1'b0};
            en = exp_r - 13'sd1;
        end
        sig = qn[QBITS-1 -: 53];
        g   = qn[QBITS-54];
        // Quotient bits below the guard position belong to sticky along with the remainder.
        s   = (|qn[QBITS-55:0]) | (|rem_r);
        inc = g & (s | sig[0]);
        sum = {1'b0, sig} + {53'd0, inc};
        mant = sum[51:0];
        ef   = en;
        if (sum[53]) begin
            mant = sum[52:1];
            ef   = en + 13'sd1;
        end
        ovf_n = (ef >= 13'sd2047);
        unf_n = (ef <= 13'sd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mb_r   <= '0;
            rem_r  <= '0;
            q_r    <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            dbz_r  <= 1'b0;
`ifdef FPU_DIV_INEXACT_EN
            inx_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        busy_r <= 1'b1;
                        ovf_r  <= 1'b0;
                        unf_r  <= 1'b0;
                        dbz_r  <= 1'b0;
`ifdef FPU_DIV_INEXACT_EN
                        inx_r  <= 1'b0;
`endif
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_r <= sign;
                    exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
                    rem_r  <= {2'b01, fa};
                    mb_r   <= {1'b1, fb};
                    q_r    <= '0;
                    cnt_r  <= CW'(QBITS - 1);
                    state  <= S_DIVIDE;
                    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                        res_r <= {1'b0, 11'h7ff, 1'b1, 51'd0};
                        state <= S_DONE;
                    end else if (a_inf) begin
                        res_r <= {sign, 11'h7ff, 52'd0};
                        state <= S_DONE;
                    end else if (b_zero) begin
                        res_r <= {sign, 11'h7ff, 52'd0};
                        dbz_r <= 1'b1;
                        state <= S_DONE;
                    end else if (a_zero | b_inf) begin
                        res_r <= {sign, 63'd0};
                        state <= S_DONE;
                    end
                end
                S_DIVIDE: begin
                    q_r   <= {q_r[QBITS-2:0], ge};
                    rem_r <= ge ? (diff << 1) : (rem_r << 1);
                    if (cnt_r == '0)
                        state <= S_ROUND;
                    else
                        cnt_r <= cnt_r - CW'(1);
                end
                S_ROUND: begin
                    ovf_r <= ovf_n;
                    unf_r <= unf_n & ~ovf_n;
                    if (ovf_n)
                        res_r <= {sign_r, 11'h7ff, 52'd0};
                    else if (unf_n)
                        res_r <= {sign_r, 63'd0};
                    else
                        res_r <= {sign_r, ef[10:0], mant};
`ifdef FPU_DIV_INEXACT_EN
                    inx_r <= g | s | ovf_n | unf_n;
`endif
                    state <= S_DONE;
                end
                S_DONE: begin
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.result      = res_r;
    assign bus.overflow    = ovf_r;
    assign bus.underflow   = unf_r;
    assign bus.div_by_zero = dbz_r;
`ifdef FPU_DIV_INEXACT_EN
    assign bus.inexact     = inx_r;
`endif
endmodule
